// File: rtl/btb_storage.sv
// 2-way 8-set BTB array + LRU vector: combinational read, 1-cycle write of LRU refresh and EX-stage training.
// Latency: zero to read, one edge to write. No backpressure: one update and one read commit accepted every cycle.
module btb_storage (
    input  logic         clk,
    input  logic         rst,
    input  logic [2:0]   read_index,
    input  logic         read_hit,
    input  logic         next_LRU_read,
    input  logic         stall,
    input  logic         update_en,
    input  logic [31:0]  update_pc,
    input  logic [31:0]  update_target,
    input  logic         update_taken,
    output logic [127:0] read_set,
    output logic [7:0]   LRU
);

    logic [127:0] r_sets [8];
    logic [7:0]   r_lru;

    logic [2:0]   w_idx;
    logic [26:0]  w_tag;
    logic [127:0] w_cur_set;
    logic [63:0]  w_way1;
    logic [63:0]  w_way2;
    logic         w_hit1;
    logic         w_hit2;
    logic [127:0] w_new_set;
    logic         w_wr_set;
    logic         w_wr_lru;
    logic         w_lru_val;
    logic [7:0]   w_lru_nxt;
    logic         w_unused_pc;

    function automatic logic [1:0] train(input logic [1:0] st, input logic taken);
        logic [1:0] nxt;
        nxt = st;
        case (st)
            2'b00:   nxt = taken ? 2'b01 : 2'b00;
            2'b01:   nxt = taken ? 2'b11 : 2'b00;
            2'b11:   nxt = taken ? 2'b10 : 2'b01;
            default: nxt = taken ? 2'b10 : 2'b11;
        endcase
        return nxt;
    endfunction

    function automatic logic [63:0] train_way(input logic [63:0] way, input logic taken,
                                              input logic [31:0] target);
        logic [63:0] w;
        w       = way;
        w[3:2]  = train(way[3:2], taken);
        w[1:0]  = 2'b00;
        if (taken)
            w[35:4] = target;
        return w;
    endfunction

    assign read_set    = r_sets[read_index];
    assign LRU         = r_lru;
    assign w_unused_pc = ^update_pc[1:0];

    assign w_idx     = update_pc[4:2];
    assign w_tag     = update_pc[31:5];
    assign w_cur_set = r_sets[w_idx];
    assign w_way1    = w_cur_set[127:64];
    assign w_way2    = w_cur_set[63:0];
    assign w_hit1    = w_way1[63] && (w_way1[62:36] == w_tag);
    assign w_hit2    = w_way2[63] && (w_way2[62:36] == w_tag) && !w_hit1;

    always_comb begin
        w_new_set = w_cur_set;
        w_wr_set  = 1'b0;
        w_wr_lru  = 1'b0;
        w_lru_val = 1'b0;
        if (update_en) begin
            if (w_hit1) begin
                w_new_set[127:64] = train_way(w_way1, update_taken, update_target);
                w_wr_set          = 1'b1;
                w_wr_lru          = 1'b1;
                w_lru_val         = 1'b0;
            end else if (w_hit2) begin
                w_new_set[63:0] = train_way(w_way2, update_taken, update_target);
                w_wr_set        = 1'b1;
                w_wr_lru        = 1'b1;
                w_lru_val       = 1'b1;
            end else if (update_taken) begin
                // Allocate into the LRU victim; it then becomes MRU, so the bit flips.
                if (r_lru[w_idx])
                    w_new_set[127:64] = {1'b1, w_tag, update_target, 2'b11, 2'b00};
                else
                    w_new_set[63:0]   = {1'b1, w_tag, update_target, 2'b11, 2'b00};
                w_wr_set  = 1'b1;
                w_wr_lru  = 1'b1;
                w_lru_val = !r_lru[w_idx];
            end
        end
    end

    // Update-side LRU write is applied last so it wins a same-bit collision.
    always_comb begin
        w_lru_nxt = r_lru;
        if (read_hit && !stall)
            w_lru_nxt[read_index] = next_LRU_read;
        if (w_wr_lru)
            w_lru_nxt[w_idx] = w_lru_val;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++)
                r_sets[i] <= '0;
            r_lru <= '0;
        end else begin
            if (w_wr_set)
                r_sets[w_idx] <= w_new_set;
            r_lru <= w_lru_nxt;
        end
    end

endmodule

// File: tb/tb_btb_storage.sv
// Directed bench for btb_storage: stimulus pushes expected read_set/LRU, a negedge monitor pops and compares.
module tb_btb_storage;

    logic         clk;
    logic         rst;
    logic [2:0]   read_index;
    logic         read_hit;
    logic         next_LRU_read;
    logic         stall;
    logic         update_en;
    logic [31:0]  update_pc;
    logic [31:0]  update_target;
    logic         update_taken;
    logic [127:0] read_set;
    logic [7:0]   LRU;

    typedef struct {
        int           id;
        logic [127:0] set;
        logic [7:0]   lru;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   next_id  = 0;

    btb_storage dut (
        .clk(clk), .rst(rst), .read_index(read_index), .read_hit(read_hit),
        .next_LRU_read(next_LRU_read), .stall(stall), .update_en(update_en),
        .update_pc(update_pc), .update_target(update_target), .update_taken(update_taken),
        .read_set(read_set), .LRU(LRU)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] mk(input logic [26:0] tag, input logic [31:0] tgt,
                                       input logic [1:0] st);
        return {1'b1, tag, tgt, st, 2'b00};
    endfunction

    // Monitor: one expectation is consumed per cycle, sampled mid-cycle.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            if (read_set !== e.set) begin
                failures++;
                $display("FAIL chk%0d read_set got=%h want=%h", e.id, read_set, e.set);
            end
            checks++;
            if (LRU !== e.lru) begin
                failures++;
                $display("FAIL chk%0d LRU got=%h want=%h", e.id, LRU, e.lru);
            end
        end
    end

    task automatic expect_rd(input logic [2:0] idx, input logic [127:0] s, input logic [7:0] l);
        exp_t e;
        read_index = idx;
        e.id  = next_id;
        e.set = s;
        e.lru = l;
        next_id++;
        q.push_back(e);
    endtask

    task automatic drive_upd(input logic [31:0] pc, input logic [31:0] tgt, input logic tk);
        update_en     = 1'b1;
        update_pc     = pc;
        update_target = tgt;
        update_taken  = tk;
    endtask

    task automatic rd_commit(input logic [2:0] idx, input logic hit, input logic nl, input logic st);
        read_index    = idx;
        read_hit      = hit;
        next_LRU_read = nl;
        stall         = st;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        update_en     = 1'b0;
        read_hit      = 1'b0;
        next_LRU_read = 1'b0;
        stall         = 1'b0;
    endtask

    // Update in one cycle, then check the result in the next.
    task automatic upd_chk(input logic [31:0] pc, input logic [31:0] tgt, input logic tk,
                           input logic [127:0] s, input logic [7:0] l);
        drive_upd(pc, tgt, tk);
        tick();
        expect_rd(pc[4:2], s, l);
        tick();
    endtask

    logic [63:0] w2;
    logic [63:0] w1;

    initial begin
        rst = 1'b0; read_index = '0; read_hit = 1'b0; next_LRU_read = 1'b0; stall = 1'b0;
        update_en = 1'b0; update_pc = '0; update_target = '0; update_taken = 1'b0;
        #1 rst = 1'b1;
        expect_rd(3'd0, '0, 8'h00);
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            expect_rd(i[2:0], '0, 8'h00);
            tick();
        end

        // Not-taken miss on empty BTB changes nothing.
        upd_chk(32'h0000_0104, 32'h0000_0200, 1'b0, '0, 8'h00);
        // First taken allocation: LRU[1]=0 so way2 is the victim.
        upd_chk(32'h0000_0104, 32'h0000_0200, 1'b1, {64'h0, mk(27'h8, 32'h200, 2'b11)}, 8'h02);
        upd_chk(32'h0000_0104, 32'h0000_0200, 1'b1, {64'h0, mk(27'h8, 32'h200, 2'b10)}, 8'h02);
        upd_chk(32'h0000_0104, 32'h0000_0200, 1'b1, {64'h0, mk(27'h8, 32'h200, 2'b10)}, 8'h02);
        upd_chk(32'h0000_0104, 32'h0000_0208, 1'b1, {64'h0, mk(27'h8, 32'h208, 2'b10)}, 8'h02);
        upd_chk(32'h0000_0104, 32'hDEAD_0000, 1'b0, {64'h0, mk(27'h8, 32'h208, 2'b11)}, 8'h02);
        upd_chk(32'h0000_0104, 32'hDEAD_0000, 1'b0, {64'h0, mk(27'h8, 32'h208, 2'b01)}, 8'h02);
        upd_chk(32'h0000_0104, 32'hDEAD_0000, 1'b0, {64'h0, mk(27'h8, 32'h208, 2'b00)}, 8'h02);
        upd_chk(32'h0000_0104, 32'hDEAD_0000, 1'b0, {64'h0, mk(27'h8, 32'h208, 2'b00)}, 8'h02);

        // Second tag at index 1 allocates way1, third evicts way2.
        w2 = mk(27'h8, 32'h208, 2'b00);
        upd_chk(32'h0000_0124, 32'h0000_0400, 1'b1, {mk(27'h9, 32'h400, 2'b11), w2}, 8'h00);
        w1 = mk(27'h9, 32'h400, 2'b11);
        upd_chk(32'h0000_0144, 32'h0000_0500, 1'b1, {w1, mk(27'hA, 32'h500, 2'b11)}, 8'h02);
        w2 = mk(27'hA, 32'h500, 2'b11);
        upd_chk(32'h0000_0124, 32'h0000_0600, 1'b1, {mk(27'h9, 32'h600, 2'b10), w2}, 8'h00);

        // Read-side LRU commit, blocked by stall and by a miss.
        rd_commit(3'd3, 1'b1, 1'b1, 1'b0);
        tick();
        expect_rd(3'd3, '0, 8'h08);
        tick();
        rd_commit(3'd3, 1'b1, 1'b0, 1'b1);
        tick();
        expect_rd(3'd3, '0, 8'h08);
        tick();
        rd_commit(3'd3, 1'b0, 1'b0, 1'b0);
        tick();
        expect_rd(3'd3, '0, 8'h08);
        tick();

        // LRU[3]=1 -> victim way1.
        upd_chk(32'h0000_010C, 32'h0000_0700, 1'b1, {mk(27'h8, 32'h700, 2'b11), 64'h0}, 8'h00);
        rd_commit(3'd3, 1'b1, 1'b1, 1'b0);
        tick();
        expect_rd(3'd3, {mk(27'h8, 32'h700, 2'b11), 64'h0}, 8'h08);
        tick();
        // Same-bit collision: update-side way1 hit wins.
        rd_commit(3'd3, 1'b1, 1'b1, 1'b0);
        upd_chk(32'h0000_010C, 32'h0000_0700, 1'b1, {mk(27'h8, 32'h700, 2'b10), 64'h0}, 8'h00);
        // Different indices: both commit; same-cycle read shows pre-update LRU.
        rd_commit(3'd5, 1'b1, 1'b1, 1'b0);
        expect_rd(3'd5, '0, 8'h00);
        drive_upd(32'h0000_010C, 32'h0000_0999, 1'b0);
        tick();
        expect_rd(3'd3, {mk(27'h8, 32'h700, 2'b11), 64'h0}, 8'h20);
        tick();
        // Same-cycle read of the set being updated returns old contents.
        drive_upd(32'h0000_010C, 32'h0000_0999, 1'b0);
        expect_rd(3'd3, {mk(27'h8, 32'h700, 2'b11), 64'h0}, 8'h20);
        tick();
        expect_rd(3'd3, {mk(27'h8, 32'h700, 2'b01), 64'h0}, 8'h20);
        tick();

        // Mid-cycle reset with an update in flight through the next edge.
        drive_upd(32'h0000_011C, 32'h0000_0800, 1'b1);
        #1 rst = 1'b1;
        expect_rd(3'd3, '0, 8'h00);
        @(posedge clk);
        #1;
        rst = 1'b0;
        update_en = 1'b0;
        expect_rd(3'd7, '0, 8'h00);
        tick();
        expect_rd(3'd1, '0, 8'h00);
        tick();
        tick();

        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d want=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/btb_storage.md
# btb_storage

Storage and update stage of the 2-way, 8-set branch target buffer. Holds the 8×128-bit set array and the 8-bit LRU vector, drives the indexed set and LRU vector to the IF-stage BTB read logic, and commits two kinds of writes: LRU refresh on IF-stage hits, and entry allocation/counter training on EX-stage branch resolution. It sits directly upstream of the BTB read/compare logic, which it feeds, and consumes that logic's hit and next-LRU outputs.

## Interface
Parameters: none (geometry fixed: 8 sets, 2 ways, 27-bit tag, 3-bit index).
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- read_index  in  3  IF-stage set index, PC[4:2]
- read_hit  in  1  IF-stage BTB hit from read logic
- next_LRU_read  in  1  LRU value for read_index computed by read logic
- stall  in  1  IF stall; blocks the read-side LRU commit
- update_en  in  1  EX-stage resolved branch/jump this cycle
- update_pc  in  32  PC of resolved instruction
- update_target  in  32  resolved target address
- update_taken  in  1  resolved direction
- read_set  out  128  set[read_index], combinational from the array
- LRU  out  8  full LRU vector, combinational from the register

## Operation
- Set layout: way1 = [127:64], way2 = [63:0]. Way layout: valid [63], tag [62:36], target [35:4], state [3:2], [1:0] always written 0.
- Update decode: index = update_pc[4:2], tag = update_pc[31:5]. Hit in way w = valid_w && tag_w == tag; way1 has priority if both match.
- LRU[i] meaning: 0 = way1 most recently used (victim way2); 1 = way2 MRU (victim way1).
- 2-bit state encoding: SNT=00, WNT=01, ST=10, WT=11; predicted taken = state[1].
- Training, taken: SNT→WNT→WT→ST→ST. Not taken: ST→WT→WNT→SNT→SNT.
- Update hit: state of the hit way trained; target overwritten with update_target only if update_taken; valid/tag unchanged; LRU[index] set to the hit way (way1→0, way2→1).
- Update miss, taken: victim way (LRU[index]==0 → way2, else way1) written with valid=1, tag, update_target, state=WT; LRU[index] set to the victim way.
- Update miss, not taken: no array or LRU change.
- Read-side commit: when read_hit && !stall, LRU[read_index] ← next_LRU_read. No commit on miss or stall.
- Collision: both commits targeting the same LRU bit in one cycle → update-side value wins. Different indices → both commit.
- update_en low: update inputs ignored.

## Timing
- Reset: all 8 sets = 128'h0 (all entries invalid), LRU = 8'h00; read_set = 0 and LRU = 0 while rst is high. Assertion mid-cycle clears immediately, discarding any in-flight update.
- read_set/LRU: zero-latency combinational read; no write-to-read bypass. An update at edge N is visible on read_set from edge N onward (i.e. in the cycle after update_en).
- Write latency: 1 cycle; throughput: one update and one read commit per cycle.
- Same-cycle read of the set being updated returns pre-update contents.

## Test plan
- Reset → read_set=0 for every read_index 0..7, LRU=8'h00; update with update_taken=0 on an empty BTB leaves everything at 0.
- update_pc=32'h0000_0104, taken, target 32'h0000_0200 → next cycle with read_index=1, read_set[63:0] = {1'b1, 27'h000008, 32'h200, 2'b11, 2'b00}, way1 untouched, LRU[1]=1.
- Same PC resolved taken three more times → state WT→ST→ST (10); then not taken ×4 → WT, WNT, SNT, SNT; target unchanged on not-taken.
- Index 1 with way2 valid (LRU[1]=1): new taken PC 32'h0000_0124 allocates way1, LRU[1]=0; third taken PC 32'h0000_0144 evicts way2 (LRU-victim), LRU[1]=1.
- read_index=3, read_hit=1, next_LRU_read=1, stall=0 → LRU[3]=1; same stimulus with stall=1 → LRU unchanged; same with concurrent way1-hit update at index 3 → LRU[3]=0.
- Update in flight, rst pulsed mid-cycle → read_set and LRU read 0 immediately; no entry written at the following edge.
